// File: rtl/gf2_poly_div_128.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : gf2_poly_div_128                                            |
// | Description : Sequential GF(2)[x] polynomial divider, 128-bit dividend by |
// |               64-bit divisor. One dividend bit is shifted in per cycle.   |
// |               Macro GF2_DIV_QUOT_EN builds the quotient register; without |
// |               it the block only reduces (quotient reads as zero).         |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
module gf2_poly_div_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] dividend,
  input  logic [63:0]  divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] quotient,
  output logic [63:0]  remainder,
  output logic         div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  a_q, a_d;
  logic [63:0]   b_q, b_d;
  logic [5:0]    degb_q, degb_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [63:0]   rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [5:0]    degb_w;
  logic [63:0]   t_w;
  logic          qbit_w;
  logic          accept_w;

  // Degree of the incoming divisor: index of its highest set bit.
  always_comb begin
    degb_w = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (divisor[i]) degb_w = i[5:0];
    end
  end

  assign accept_w = in_valid && (state_q == IDLE);
  // Shift the next dividend bit into the partial remainder; its top bit
  // (at the divisor degree) decides whether the divisor is subtracted.
  assign t_w      = {rem_q[62:0], a_q[cnt_q]};
  assign qbit_w   = t_w[degb_q];

  // Next-state, handshake outputs and remainder datapath.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    degb_d    = degb_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d    = dividend;
          b_d    = divisor;
          degb_d = degb_w;
          rem_d  = 64'd0;
          cnt_d  = 7'd127;
          if (divisor == 64'd0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = qbit_w ? (t_w ^ b_q) : t_w;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 128'd0;
      b_q     <= 64'd0;
      degb_q  <= 6'd0;
      cnt_q   <= 7'd0;
      rem_q   <= 64'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      degb_q  <= degb_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

`ifdef GF2_DIV_QUOT_EN
  logic [127:0] quo_q, quo_d;

  // Quotient collects one decision bit per step, MSB first.
  always_comb begin
    quo_d = quo_q;
    if (accept_w)              quo_d = 128'd0;
    else if (state_q == BUSY)  quo_d = {quo_q[126:0], qbit_w};
  end

  // Quotient shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) quo_q <= 128'd0;
    else        quo_q <= quo_d;
  end

  assign quotient = quo_q;
`else
  assign quotient = 128'd0;
`endif

  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule
`default_nettype wire

// File: doc/gf2_poly_div_128.md
GF2_POLY_DIV_128 -- requirements
Module: gf2_poly_div_128

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  dividend and divisor are valid.
REQ-005 in_ready  output  1  block accepts a new operand pair.
REQ-006 dividend  input  128  GF(2)[x] dividend A, bit i = coefficient of x^i.
REQ-007 divisor  input  64  GF(2)[x] divisor B, bit i = coefficient of x^i.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 quotient  output  128  Q, where A = Q*B + R, using carry-less arithmetic.
REQ-011 remainder  output  64  R, with deg(R) < deg(B).
REQ-012 div_zero  output  1  B was zero for the current result.

Function
REQ-013 The block SHALL be the inverse of the team's carry-less multipliers: for any B != 0, clmul(Q,B) XOR R SHALL equal A.
REQ-014 FSM states SHALL be IDLE, BUSY and DONE.
REQ-015 IDLE SHALL drive in_ready=1 and out_valid=0. BUSY and DONE SHALL drive in_ready=0; no input overlaps an active operation.
REQ-016 An accept edge (in_valid & in_ready) with B != 0 SHALL:
  - latch A and B;
  - latch degB = index of the highest set bit of B;
  - clear R and Q;
  - set the bit counter to 127;
  - enter BUSY.
REQ-017 Each BUSY cycle SHALL perform one step:
  - t = {R[62:0], A[cnt]};
  - qbit = t[degB];
  - R = qbit ? t XOR B : t;
  - Q = {Q[126:0], qbit};
  - cnt decrements.
REQ-018 After the step with cnt=0, the FSM SHALL enter DONE. Accept-to-out_valid latency SHALL be exactly 129 cycles (128 BUSY steps plus the transition).
REQ-019 An accept edge with B=0 SHALL go directly to DONE on the next edge with quotient=0, remainder=0, div_zero=1 (latency 1 cycle).
REQ-020 DONE SHALL hold out_valid=1 with quotient, remainder and div_zero stable until out_ready=1, then return to IDLE on that edge.
REQ-021 out_valid and out_ready high together in DONE SHALL complete the transfer. in_ready SHALL rise one cycle later; there is no same-cycle re-accept.
REQ-022 The result outputs SHALL hold their last value in IDLE. div_zero SHALL clear on the next accept with B != 0.
REQ-023 divisor=1 SHALL yield Q=A and R=0. deg(A) < deg(B) SHALL yield Q=0 and R=A[63:0].

Reset
REQ-024 rst_n low SHALL immediately force:
  - state IDLE, in_ready=1, out_valid=0;
  - quotient=0, remainder=0, div_zero=0;
  - counter=0.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation with no result emitted. The first accept after rst_n rises SHALL behave as from power-up.

Configuration
REQ-026 Macro GF2_DIV_QUOT_EN:
  - Defined: the Q shift register is built and quotient carries Q.
  - Undefined: the block is reduction-only. The Q register is omitted, quotient is tied to 0, and remainder, latency and handshake are unchanged.

Verification
REQ-027 A=0x0F, B=0x3 -> Q=0x5, R=0x0, div_zero=0, out_valid exactly 129 cycles after accept.
REQ-028 A=0x13, B=0x3 -> Q=0xE, R=0x1. A=0x5, B=0x8 -> Q=0x0, R=0x5.
REQ-029 A=1<<127, B=1<<63 -> Q=1<<64, R=0. A=random 128-bit, B=0x1 -> Q=A, R=0.
REQ-030 B=0, any A -> out_valid after 1 cycle with Q=0, R=0, div_zero=1. A following valid B -> div_zero=0.
REQ-031 Back-pressure: out_ready held low for 20 cycles in DONE -> outputs stable, in_ready=0. out_ready pulse -> IDLE, in_ready=1 on the next cycle.
REQ-032 rst_n pulsed low at BUSY step 60 -> out_valid stays 0, outputs=0. A new operation A=0x13, B=0x3 then completes correctly.
